lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_mem_stage_if.sv | 21 ++
 rtl/lsu_mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the LSU memory stage (master) and the data memory (slave).
interface lsu_mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: stalls the pipeline over a req/gnt/rvalid data-memory
// handshake, formats load data and store lanes, flags misaligned/illegal accesses and timeouts.
module lsu_mem_stage #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            instr_m,
    input  logic [31:0]            ALUResult_m,
    input  logic [31:0]            WriteData_m,
    input  logic                   MemWrite_m,
    input  logic [1:0]             ResultSrc_m,
    output logic [31:0]            ReadData_m,
    output logic                   stall_m,
    output logic                   access_fault,
    output logic                   timeout,
    lsu_mem_stage_if.master        dmem
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [2:0]      f3;
    logic            is_store, is_load, access, misaligned, illegal_f3, fault;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^{instr_m[31:15], instr_m[11:0]};

    function automatic logic [31:0] fmt_load(input logic [2:0] fn, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (fn)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'd0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'd0, h};
            3'b010:  fmt_load = word;
            default: fmt_load = '0;
        endcase
    endfunction

    always_comb begin
        f3         = instr_m[14:12];
        is_store   = MemWrite_m;
        is_load    = ~MemWrite_m & (ResultSrc_m == 2'b01);
        access     = is_store | is_load;
        misaligned = ((f3[1:0] == 2'b01) && ALUResult_m[0]) ||
                     ((f3[1:0] == 2'b10) && (ALUResult_m[1:0] != 2'b00));
        case (f3)
            3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
            3'b100, 3'b101:         illegal_f3 = is_store;
            default:                illegal_f3 = 1'b1;
        endcase
        fault = access & (misaligned | illegal_f3);

        st_be    = '0;
        st_wdata = '0;
        case (f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ALUResult_m[1:0];
                st_wdata = {4{WriteData_m[7:0]}};
            end
            2'b01: begin
                st_be    = ALUResult_m[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{WriteData_m[15:0]}};
            end
            2'b10: begin
                st_be    = 4'b1111;
                st_wdata = WriteData_m;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        funct3_d        = funct3_q;
        we_d            = we_q;
        be_d            = be_q;
        cnt_d           = cnt_q;
        stall_m         = 1'b0;
        ReadData_m      = '0;
        access_fault    = 1'b0;
        timeout         = 1'b0;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        dmem.dmem_be    = '0;

        case (state_q)
            IDLE: begin
                if (access && fault) begin
                    access_fault = 1'b1;
                end else if (access) begin
                    stall_m  = 1'b1;
                    addr_d   = ALUResult_m;
                    funct3_d = f3;
                    we_d     = is_store;
                    wdata_d  = is_store ? st_wdata : '0;
                    be_d     = is_store ? st_be : 4'b1111;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                stall_m = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // Timeout takes priority: the request is withdrawn, so a gnt this cycle is no handshake.
                if (cnt_q == LIMIT) begin
                    timeout = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    dmem.dmem_req   = 1'b1;
                    dmem.dmem_we    = we_q;
                    dmem.dmem_addr  = {addr_q[31:2], 2'b00};
                    dmem.dmem_wdata = wdata_q;
                    dmem.dmem_be    = be_q;
                    if (dmem.dmem_gnt) begin
                        if (we_q) begin
                            state_d = DONE;
                        end else if (dmem.dmem_rvalid) begin
                            rdata_d = fmt_load(funct3_q, addr_q[1:0], dmem.dmem_rdata);
                            state_d = DONE;
                        end else begin
                            state_d = RESP;
                        end
                    end
                end
            end
            RESP: begin
                stall_m = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (dmem.dmem_rvalid) begin
                    rdata_d = fmt_load(funct3_q, addr_q[1:0], dmem.dmem_rdata);
                    state_d = DONE;
                end else if (cnt_q == LIMIT) begin
                    timeout = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                ReadData_m = rdata_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are forced quiet while reset is held, even before the state register clears.
        if (!rst_n) begin
            stall_m         = 1'b0;
            ReadData_m      = '0;
            access_fault    = 1'b0;
            timeout         = 1'b0;
            dmem.dmem_req   = 1'b0;
            dmem.dmem_we    = 1'b0;
            dmem.dmem_addr  = '0;
            dmem.dmem_wdata = '0;
            dmem.dmem_be    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            be_q     <= be_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a bench-side memory answers the handshake and a
// scoreboard queue holds the expected ReadData_m of each issued access.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_m, ALUResult_m, WriteData_m, ReadData_m;
    logic        MemWrite_m, stall_m, access_fault, timeout;
    logic [1:0]  ResultSrc_m;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];

    lsu_mem_stage_if dmem();

    lsu_mem_stage #(.MEM_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_m      (instr_m),
        .ALUResult_m  (ALUResult_m),
        .WriteData_m  (WriteData_m),
        .MemWrite_m   (MemWrite_m),
        .ResultSrc_m  (ResultSrc_m),
        .ReadData_m   (ReadData_m),
        .stall_m      (stall_m),
        .access_fault (access_fault),
        .timeout      (timeout),
        .dmem         (dmem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        instr_m     = '0;
        ALUResult_m = '0;
        WriteData_m = '0;
        MemWrite_m  = 1'b0;
        ResultSrc_m = 2'b00;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        clear_inputs();
        #4;
        chk({tag, "_stall"}, {31'd0, stall_m}, 32'd0);
        chk({tag, "_req"},   {31'd0, dmem.dmem_req}, 32'd0);
        chk({tag, "_rd"},    ReadData_m, 32'd0);
    endtask

    // Issues one access and plays the memory: gnt after gnt_wait request cycles,
    // rvalid rv_wait cycles after gnt (0 = same cycle).
    task automatic do_access(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gnt_wait, input int rv_wait, input logic [31:0] mem_word,
                             input logic [31:0] exp_rd, input int exp_stall, input int exp_reqs,
                             input int exp_to, input int exp_flt, input logic [31:0] exp_daddr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int stalls, reqs, tos, flts, since;
        logic granted, done, gnt_now, rv_now;
        @(posedge clk); #1;
        instr_m     = {17'd0, f3, 12'd0};
        ALUResult_m = addr;
        WriteData_m = wd;
        MemWrite_m  = st;
        ResultSrc_m = st ? 2'b00 : 2'b01;
        sb.push_back(exp_rd);
        stalls = 0; reqs = 0; tos = 0; flts = 0; since = 0;
        granted = 1'b0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            gnt_now = dmem.dmem_req && (reqs == gnt_wait);
            rv_now  = !st && ((gnt_now && rv_wait == 0) || (granted && since == rv_wait));
            dmem.dmem_gnt    = gnt_now;
            dmem.dmem_rvalid = rv_now;
            dmem.dmem_rdata  = rv_now ? mem_word : 32'h5A5A_5A5A;
            #4;
            if (timeout) tos++;
            if (access_fault) flts++;
            if (dmem.dmem_req) begin
                if (reqs == 0) begin
                    chk({tag, "_addr"}, dmem.dmem_addr, exp_daddr);
                    chk({tag, "_be"},   {28'd0, dmem.dmem_be}, {28'd0, exp_be});
                    chk({tag, "_we"},   {31'd0, dmem.dmem_we}, {31'd0, st});
                    if (st) chk({tag, "_wdata"}, dmem.dmem_wdata, exp_wd);
                end
                reqs++;
            end
            if (stall_m) begin
                stalls++;
            end else begin
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    chk({tag, "_rdata"}, ReadData_m, sb.pop_front());
                end
                done = 1'b1;
            end
            if (gnt_now) begin
                granted = 1'b1;
                since   = 1;
            end else if (granted) begin
                since++;
            end
        end
        dmem.dmem_gnt    = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        chk({tag, "_completed"}, {31'd0, done}, 32'd1);
        chk({tag, "_stalls"}, stalls, exp_stall);
        chk({tag, "_reqs"},   reqs,   exp_reqs);
        chk({tag, "_timeout"}, tos,   exp_to);
        chk({tag, "_fault"},  flts,   exp_flt);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        dmem.dmem_gnt    = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #5;
        chk("rst_req",   {31'd0, dmem.dmem_req}, 32'd0);
        chk("rst_we",    {31'd0, dmem.dmem_we}, 32'd0);
        chk("rst_stall", {31'd0, stall_m}, 32'd0);
        chk("rst_flt",   {31'd0, access_fault}, 32'd0);
        chk("rst_to",    {31'd0, timeout}, 32'd0);
        chk("rst_be",    {28'd0, dmem.dmem_be}, 32'd0);
        chk("rst_addr",  dmem.dmem_addr, 32'd0);
        chk("rst_wdata", dmem.dmem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_check("idle0");

        //        tag     st  f3      addr          wd            gw rw mem_word      exp_rd        stl req to flt daddr         be       wd
        do_access("lb",   0, 3'b000, 32'h0000_0103, 32'h0,        0, 1, 32'h80FF_0000, 32'hFFFF_FF80, 3, 1, 0, 0, 32'h0000_0100, 4'b1111, 32'h0);
        do_access("sh",   1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 0, 32'h0,        32'h0,        2, 1, 0, 0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
        do_access("sb",   1, 3'b000, 32'h0000_0301, 32'hDEAD_BEEF, 0, 0, 32'h0,        32'h0,        2, 1, 0, 0, 32'h0000_0300, 4'b0010, 32'hEFEF_EFEF);
        do_access("sw",   1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 1, 0, 32'h0,        32'h0,        3, 2, 0, 0, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D);
        do_access("lw",   0, 3'b010, 32'h0000_0008, 32'h0,        0, 0, 32'h1357_9BDF, 32'h1357_9BDF, 2, 1, 0, 0, 32'h0000_0008, 4'b1111, 32'h0);
        do_access("lh",   0, 3'b001, 32'h0000_0006, 32'h0,        2, 1, 32'h8001_7FFF, 32'hFFFF_8001, 5, 3, 0, 0, 32'h0000_0004, 4'b1111, 32'h0);
        do_access("lwmis",0, 3'b010, 32'h0000_0005, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0);
        do_access("sbu",  1, 3'b100, 32'h0000_0010, 32'h0000_00FF, 0, 0, 32'h0,       32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0);
        do_access("lhto", 0, 3'b101, 32'h0000_0002, 32'h0,        1000, 0, 32'h0,     32'h0,        9, 7, 1, 0, 32'h0000_0000, 4'b1111, 32'h0);
        idle_check("idle_to");

        // Reset while waiting in RESP, then a stale rvalid
        @(posedge clk); #1;
        instr_m = {17'd0, 3'b010, 12'd0}; ALUResult_m = 32'h0000_0010; ResultSrc_m = 2'b01;
        @(posedge clk); #1;
        dmem.dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem.dmem_gnt = 1'b0;
        #4;
        chk("resp_stall", {31'd0, stall_m}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_inputs();
        #4;
        chk("rstresp_stall", {31'd0, stall_m}, 32'd0);
        chk("rstresp_req",   {31'd0, dmem.dmem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = 32'hFFFF_FFFF;
        #4;
        chk("post_rst_stall", {31'd0, stall_m}, 32'd0);
        chk("post_rst_req",   {31'd0, dmem.dmem_req}, 32'd0);
        chk("post_rst_rd",    ReadData_m, 32'd0);
        chk("post_rst_be",    {28'd0, dmem.dmem_be}, 32'd0);
        @(posedge clk); #1;
        dmem.dmem_rvalid = 1'b0;
        #4;
        chk("stale_rv_rd", ReadData_m, 32'd0);
        do_access("lbu",  0, 3'b100, 32'h0000_0001, 32'h0,        0, 0, 32'h0000_AB00, 32'h0000_00AB, 2, 1, 0, 0, 32'h0000_0000, 4'b1111, 32'h0);
        idle_check("idle_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
